// File: rtl/dense_result_buffer.sv
// Result FIFO for the dense accelerator: optional ReLU on capture, host-drained
// queue with registered read port, plus running max/argmax over accepted results.
module dense_result_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] resultIn,
    input  logic              resultValid,
    input  logic              reluEnable,
    input  logic              readReq,
    input  logic              clearStats,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataOutValid,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic [DATA_W-1:0] maxValue,
    output logic [IDX_W-1:0]  argmaxIdx
);

    localparam logic [DATA_W-1:0] MAX_RESET = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]  IDX_SAT   = '1;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] value;
    logic              pop_ok;
    logic              push_ok;
    logic              drop;
    logic [DATA_W-1:0] base_max;
    logic [IDX_W-1:0]  base_idx;
    logic              new_max;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    always_comb begin
        value    = (reluEnable && resultIn[DATA_W-1]) ? '0 : resultIn;
        pop_ok   = readReq && !empty;
        // A full FIFO still accepts a push when the same edge frees the head slot.
        push_ok  = resultValid && (!full || pop_ok);
        drop     = resultValid && full && !pop_ok;
        // clearStats is applied before scoring a same-cycle push.
        base_max = clearStats ? MAX_RESET : maxValue;
        base_idx = clearStats ? '0 : idx;
        new_max  = $signed(value) > $signed(base_max);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            dataOut      <= '0;
            dataOutValid <= 1'b0;
        end else begin
            dataOutValid <= pop_ok;
            if (pop_ok) begin
                dataOut <= mem[rptr];
                rptr    <= rptr + ADDR_W'(1);
            end
            if (push_ok) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (ADDR_W+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            maxValue  <= MAX_RESET;
            argmaxIdx <= '0;
            idx       <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                maxValue  <= new_max ? value : base_max;
                argmaxIdx <= new_max ? base_idx : (clearStats ? '0 : argmaxIdx);
                idx       <= (base_idx == IDX_SAT) ? IDX_SAT : base_idx + IDX_W'(1);
            end else if (clearStats) begin
                maxValue  <= MAX_RESET;
                argmaxIdx <= '0;
                idx       <= '0;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clearStats) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dense_result_buffer.sv
// Randomized + directed bench for dense_result_buffer: a queue-based reference
// model predicts popped words and stats; a negedge monitor scores each pop.
module tb_dense_result_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int IDX_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] resultIn;
    logic              resultValid;
    logic              reluEnable;
    logic              readReq;
    logic              clearStats;
    logic [DATA_W-1:0] dataOut;
    logic              dataOutValid;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic [DATA_W-1:0] maxValue;
    logic [IDX_W-1:0]  argmaxIdx;

    always #5 clk = ~clk;

    dense_result_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset(reset), .resultIn(resultIn), .resultValid(resultValid),
        .reluEnable(reluEnable), .readReq(readReq), .clearStats(clearStats),
        .dataOut(dataOut), .dataOutValid(dataOutValid), .count(count),
        .empty(empty), .full(full), .overflow(overflow),
        .maxValue(maxValue), .argmaxIdx(argmaxIdx)
    );

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_fifo[$];
    logic [DATA_W-1:0] m_max;
    int                m_arg;
    int                m_idx;
    bit                m_ovf;
    bit                m_valid;
    int                n_cmp = 0;
    int                n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest predicted pop.
    always @(negedge clk) begin
        if (dataOutValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 64'(dataOut), 64'hDEAD_BEEF_0000_0000);
            end else begin
                check("dataOut", 64'(dataOut), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input bit rst, input bit rv, input logic [DATA_W-1:0] d,
                        input bit relu, input bit rd, input bit clr);
        logic [DATA_W-1:0] v;
        bit pop_ok;
        bit push_ok;
        reset = rst; resultValid = rv; resultIn = d;
        reluEnable = relu; readReq = rd; clearStats = clr;
        @(posedge clk);
        v = (relu && d[DATA_W-1]) ? '0 : d;
        if (rst) begin
            model_fifo.delete();
            m_max = 32'h8000_0000; m_arg = 0; m_idx = 0; m_ovf = 0; m_valid = 0;
        end else begin
            pop_ok  = rd && (model_fifo.size() > 0);
            push_ok = rv && ((model_fifo.size() < DEPTH) || pop_ok);
            m_valid = pop_ok;
            if (pop_ok) exp_q.push_back(model_fifo.pop_front());
            if (clr) begin
                m_max = 32'h8000_0000; m_arg = 0; m_idx = 0; m_ovf = 0;
            end
            if (push_ok) begin
                model_fifo.push_back(v);
                if ($signed(v) > $signed(m_max)) begin
                    m_max = v;
                    m_arg = m_idx;
                end
                if (m_idx < (1 << IDX_W) - 1) m_idx++;
            end else if (rv) begin
                m_ovf = 1;
            end
        end
        @(negedge clk);
        check("count", 64'(count), 64'(model_fifo.size()));
        check("empty", 64'(empty), 64'(model_fifo.size() == 0));
        check("full", 64'(full), 64'(model_fifo.size() == DEPTH));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("maxValue", 64'(maxValue), 64'(m_max));
        check("argmaxIdx", 64'(argmaxIdx), 64'(m_arg));
        check("dataOutValid", 64'(dataOutValid), 64'(m_valid));
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input bit relu);
        step(0, 1, d, relu, 0, 0);
    endtask

    task automatic read1();
        step(0, 0, '0, 0, 1, 0);
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0);
    endtask

    function automatic logic [DATA_W-1:0] rand_value();
        logic [DATA_W-1:0] r;
        case ($urandom_range(0, 3))
            0: r = $urandom;
            1: r = DATA_W'($urandom_range(0, 8)) << 24;
            2: r = -(DATA_W'($urandom_range(1, 8)) << 24);
            default: r = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        endcase
        return r;
    endfunction

    initial begin
        reset = 1; resultValid = 0; resultIn = '0;
        reluEnable = 0; readReq = 0; clearStats = 0;
        step(1, 0, '0, 0, 0, 0);
        step(1, 0, '0, 0, 0, 0);

        // Basic in-order push/pop
        push(32'h0100_0000, 0); push(32'h0200_0000, 0); push(32'h0300_0000, 0);
        read1(); read1(); read1(); idle();

        // ReLU clamping and argmax, then the same values unclamped
        step(0, 0, '0, 0, 0, 1);
        push(32'hFF00_0000, 1); push(32'h0080_0000, 1); push(32'hFE00_0000, 1);
        read1(); read1(); read1();
        step(0, 0, '0, 0, 0, 1);
        push(32'hFF00_0000, 0); push(32'h0080_0000, 0); push(32'hFE00_0000, 0);
        read1(); read1(); read1(); idle();

        // Fill, overflow drop, push+pop while full, wrap-around drain
        step(0, 0, '0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) push(DATA_W'(i) << 24, 0);
        push(32'h1100_0000, 0);
        step(0, 1, 32'h2200_0000, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) read1();
        idle();

        // Simultaneous push and read on an empty FIFO: no bypass
        step(0, 1, 32'h0A00_0000, 0, 1, 0);
        read1(); idle();

        // Ties keep the first index; clear coincident with a push
        step(0, 0, '0, 0, 0, 1);
        push(32'h0200_0000, 0); push(32'h0500_0000, 0); push(32'h0500_0000, 0);
        step(0, 1, 32'hF000_0000, 0, 0, 1);
        for (int i = 0; i < 4; i++) read1();
        idle();

        // Reset mid-stream with a read strobe asserted
        for (int i = 0; i < 5; i++) push(DATA_W'(i + 1) << 20, 0);
        step(1, 0, '0, 0, 1, 0);
        idle();

        // Randomized traffic: fill-biased phase, then drain-biased phase
        for (int i = 0; i < 3000; i++) begin
            int rd_pct;
            rd_pct = (i < 1500) ? 30 : 70;
            step(($urandom_range(0, 999) == 0),
                 ($urandom_range(0, 99) < 60),
                 rand_value(),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 99) < rd_pct),
                 ($urandom_range(0, 399) == 0));
        end

        for (int i = 0; i < DEPTH + 2; i++) read1();
        idle(); idle();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
